ssp_rx_shifter: RTL



---
 rtl/ssp_pkg.sv | 13 +
 rtl/ssp_sync.sv | 30 +++
 rtl/ssp_rx_shifter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP receive path.
package ssp_pkg;

  localparam int SSP_DATA_W   = 8;
  localparam int SSP_SYNC_MIN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } ssp_rx_state_t;

endpackage

// File: rtl/ssp_sync.sv
// Multi-flop synchroniser for one asynchronous input, resetting to a chosen level.
module ssp_sync import ssp_pkg::*; #(
  parameter int   STAGES  = SSP_SYNC_MIN,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int N = (STAGES < SSP_SYNC_MIN) ? SSP_SYNC_MIN : STAGES;

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;

  assign chain_d = {chain_q[N-2:0], d_i};

  // Synchroniser chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {N{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[N-1];

endmodule

// File: rtl/ssp_rx_shifter.sv
// SSP serial receive shifter: synchronises SSPCLKIN/SSPFSSIN/SSPRXD and pushes MSB-first words to the RX FIFO.
// Optional sticky overrun flag enabled by defining SSP_RX_OVERRUN_EN.
module ssp_rx_shifter import ssp_pkg::*; #(
  parameter int DATA_W      = SSP_DATA_W,
  parameter int SYNC_STAGES = SSP_SYNC_MIN
) (
  input  logic              PCLK_RX,
  input  logic              CLEAR_RX,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  input  logic              RX_EN,
  input  logic              FIFO_FULL,
  input  logic              ROR_CLR,
  output logic [DATA_W-1:0] RxData,
  output logic              PWRITE_RX,
  output logic              PSEL_RX,
  output logic              SSPRORINTR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  ssp_rx_state_t     state_q;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic [DATA_W-1:0] rx_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              busy_q;
  logic              sclk_prev_q;

  logic sclk_s;
  logic fss_s;
  logic rxd_s;
  logic sclk_rise_s;
  logic start_s;
  logic abort_s;
  logic last_bit_s;
  logic push_s;
  logic ovr_set_s;

  ssp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i (PCLK_RX),
    .rst_i (CLEAR_RX),
    .d_i   (SSPCLKIN),
    .q_o   (sclk_s)
  );

  ssp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_fss (
    .clk_i (PCLK_RX),
    .rst_i (CLEAR_RX),
    .d_i   (SSPFSSIN),
    .q_o   (fss_s)
  );

  ssp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rxd (
    .clk_i (PCLK_RX),
    .rst_i (CLEAR_RX),
    .d_i   (SSPRXD),
    .q_o   (rxd_s)
  );

  // Previous synced serial clock for rise detection.
  always_ff @(posedge PCLK_RX or posedge CLEAR_RX) begin
    if (CLEAR_RX) begin
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign start_s     = ~fss_s & RX_EN;
  assign abort_s     = fss_s | ~RX_EN;
  assign sr_d        = {sr_q[DATA_W-2:0], rxd_s};
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign last_bit_s  = (cnt_q == CNT_W'(DATA_W - 1));

  // Receive FSM; an abort takes priority over a coincident serial clock rise.
  always_ff @(posedge PCLK_RX or posedge CLEAR_RX) begin
    if (CLEAR_RX) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_s) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort_s) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (sclk_rise_s) begin
            sr_q <= sr_d;
            if (last_bit_s) begin
              rx_data_q <= sr_d;
              cnt_q     <= '0;
              state_q   <= PUSH;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            state_q <= SHIFT;
          end
        end
        PUSH: begin
          cnt_q <= '0;
          if (start_s) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO_FULL is only looked at while the word is being offered.
  assign push_s    = (state_q == PUSH) & ~FIFO_FULL;
  assign ovr_set_s = (state_q == PUSH) & FIFO_FULL;

`ifdef SSP_RX_OVERRUN_EN
  logic ror_q;

  // Sticky overrun; a set in the same cycle as a clear wins.
  always_ff @(posedge PCLK_RX or posedge CLEAR_RX) begin
    if (CLEAR_RX) begin
      ror_q <= 1'b0;
    end else if (ovr_set_s) begin
      ror_q <= 1'b1;
    end else if (ROR_CLR) begin
      ror_q <= 1'b0;
    end else begin
      ror_q <= ror_q;
    end
  end

  assign SSPRORINTR = ror_q;
`else
  logic unused_ror_s;
  assign unused_ror_s = ROR_CLR ^ ovr_set_s;
  assign SSPRORINTR   = 1'b0;
`endif

  assign RxData    = rx_data_q;
  assign PWRITE_RX = push_s;
  assign PSEL_RX   = push_s;
  assign BUSY      = busy_q;

endmodule
